// File: rtl/boot_pkg.sv
// Shared types and framing constants for the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream receive channel plus instruction-memory write port of the boot loader.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 32
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/boot_word_assembler.sv
// Packs a big-endian byte stream into words; word_valid flags the byte that completes one.
module boot_word_assembler
  import boot_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        byte_en,
  input  logic [7:0]                  byte_in,
  output logic [8*BYTES_PER_WORD-1:0] word,
  output logic                        word_valid
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [8*BYTES_PER_WORD-1:0] shift_q;
  logic [CNT_W-1:0]            byte_cnt;

  // Word is presented combinationally so the parent can register the write on the same edge.
  assign word       = {shift_q[8*BYTES_PER_WORD-9:0], byte_in};
  assign word_valid = byte_en && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q  <= '0;
      byte_cnt <= '0;
    end else if (byte_en) begin
      shift_q  <= word;
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a length-prefixed program image, writes it into instruction memory,
// verifies the XOR checksum and releases the core reset on success.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned       IMEM_WORDS = 64,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  imem_boot_loader_if.master   bus,
  output logic                 cpu_reset_n,
  output logic                 boot_done,
  output logic                 boot_error
);

  localparam int unsigned IDX_W = $clog2(IMEM_WORDS + 1);
  localparam int unsigned LEN_W = 8 * HDR_BYTES;

  state_t            state;
  logic [7:0]        len_hi;
  logic [LEN_W-1:0]  len;
  logic [IDX_W-1:0]  word_idx;
  logic [7:0]        csum;

  logic              xfer;
  logic              byte_en;
  logic [LEN_W-1:0]  hdr_len;
  logic              last_word;
  logic [31:0]       word;
  logic              word_valid;

  assign xfer      = bus.rx_valid & bus.rx_ready;
  assign byte_en   = xfer && (state == DATA);
  assign hdr_len   = LEN_W'({len_hi, bus.rx_data});
  assign last_word = (LEN_W'(word_idx) == len - LEN_W'(1));

  boot_word_assembler u_word_asm (
    .clock      (clock),
    .reset_n    (reset_n),
    .byte_en    (byte_en),
    .byte_in    (bus.rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= LEN_HI;
      len_hi         <= '0;
      len            <= '0;
      word_idx       <= '0;
      csum           <= '0;
      bus.rx_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= BASE_ADDR;
      bus.imem_wdata <= '0;
      cpu_reset_n    <= 1'b0;
      boot_done      <= 1'b0;
      boot_error     <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      // Write is issued the cycle after the completing byte; address/data then hold.
      if (word_valid) begin
        bus.imem_we    <= 1'b1;
        bus.imem_addr  <= BASE_ADDR + ADDR_W'(word_idx) * ADDR_W'(BYTES_PER_WORD);
        bus.imem_wdata <= word;
      end

      unique case (state)
        LEN_HI: begin
          bus.rx_ready <= 1'b1;
          if (xfer) begin
            len_hi <= bus.rx_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len <= hdr_len;
            if (hdr_len > LEN_W'(IMEM_WORDS)) begin
              state        <= ERR;
              bus.rx_ready <= 1'b0;
              boot_error   <= 1'b1;
            end else if (hdr_len == '0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            csum <= csum ^ bus.rx_data;
            if (word_valid) begin
              word_idx <= word_idx + IDX_W'(1);
              if (last_word) state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            bus.rx_ready <= 1'b0;
            if (bus.rx_data == csum) begin
              state       <= DONE;
              boot_done   <= 1'b1;
              cpu_reset_n <= 1'b1;
            end else begin
              state      <= ERR;
              boot_error <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          bus.rx_ready <= 1'b0;
        end
        default: begin
          state        <= ERR;
          bus.rx_ready <= 1'b0;
          boot_error   <= 1'b1;
        end
      endcase
    end
  end

endmodule
